// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe computer opponent: cell codes, FSM states,
// line/preference tables and latencies. TTT_MOVEGEN_BLOCK_EN enables the block pass.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY    = 2'b00;
   localparam logic [1:0] CELL_PLAYER   = 2'b01;
   localparam logic [1:0] CELL_COMPUTER = 2'b10;

   localparam logic [3:0] LAST_LINE = 4'd7;
   localparam logic [3:0] LAST_PREF = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SCAN_WIN   = 3'd1,
`ifdef TTT_MOVEGEN_BLOCK_EN
      ST_SCAN_BLOCK = 3'd2,
`endif
      ST_SCAN_PREF  = 3'd3,
      ST_ISSUE      = 3'd4,
      ST_WAIT_DROP  = 3'd5
   } state_t;

   // Cycles from the capture edge to pc for index 0 of each pass.
   localparam logic [4:0] LAT_WIN   = 5'd2;
`ifdef TTT_MOVEGEN_BLOCK_EN
   localparam logic [4:0] LAT_BLOCK = 5'd10;
   localparam logic [4:0] LAT_PREF  = 5'd18;
`else
   localparam logic [4:0] LAT_PREF  = 5'd10;
`endif
   localparam logic [4:0] LAT_WORST = LAT_PREF + 5'd8;

   function automatic logic [3:0] line_cell(input logic [2:0] line, input logic [1:0] slot);
      logic [11:0] cells;
      logic [3:0]  result;
      case (line)
         3'd0:    cells = {4'd0, 4'd1, 4'd2};
         3'd1:    cells = {4'd3, 4'd4, 4'd5};
         3'd2:    cells = {4'd6, 4'd7, 4'd8};
         3'd3:    cells = {4'd0, 4'd3, 4'd6};
         3'd4:    cells = {4'd1, 4'd4, 4'd7};
         3'd5:    cells = {4'd2, 4'd5, 4'd8};
         3'd6:    cells = {4'd0, 4'd4, 4'd8};
         3'd7:    cells = {4'd2, 4'd4, 4'd6};
         default: cells = 12'd0;
      endcase
      case (slot)
         2'd0:    result = cells[11:8];
         2'd1:    result = cells[7:4];
         default: result = cells[3:0];
      endcase
      return result;
   endfunction

   function automatic logic [3:0] pref_cell(input logic [3:0] idx);
      logic [3:0] result;
      case (idx)
         4'd0:    result = 4'd4;
         4'd1:    result = 4'd0;
         4'd2:    result = 4'd2;
         4'd3:    result = 4'd6;
         4'd4:    result = 4'd8;
         4'd5:    result = 4'd1;
         4'd6:    result = 4'd3;
         4'd7:    result = 4'd5;
         4'd8:    result = 4'd7;
         default: result = 4'd0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational check of one board line: two cells owned by i_owner plus one empty cell
// is a hit, and o_slot names the empty position within the line.
module ttt_line_eval
   import ttt_pkg::*;
(
   input  logic [1:0] i_cell_a,
   input  logic [1:0] i_cell_b,
   input  logic [1:0] i_cell_c,
   input  logic [1:0] i_owner,
   output logic       o_hit,
   output logic [1:0] o_slot
);

   // Locate the single empty cell among two owned ones.
   always_comb begin
      o_hit  = 1'b0;
      o_slot = 2'd0;
      if ((i_cell_a == CELL_EMPTY) && (i_cell_b == i_owner) && (i_cell_c == i_owner)) begin
         o_hit  = 1'b1;
         o_slot = 2'd0;
      end else if ((i_cell_a == i_owner) && (i_cell_b == CELL_EMPTY) && (i_cell_c == i_owner)) begin
         o_hit  = 1'b1;
         o_slot = 2'd1;
      end else if ((i_cell_a == i_owner) && (i_cell_b == i_owner) && (i_cell_c == CELL_EMPTY)) begin
         o_hit  = 1'b1;
         o_slot = 2'd2;
      end else begin
         o_hit  = 1'b0;
         o_slot = 2'd0;
      end
   end

endmodule

// File: rtl/ttt_move_generator.sv
// Computer opponent: snapshots the board on request, scans win / block / preference one
// candidate per cycle, then issues one move strobe. Block pass needs TTT_MOVEGEN_BLOCK_EN.
module ttt_move_generator
   import ttt_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   input  logic       req,
   input  logic       game_over,
   output logic [3:0] computer_position,
   output logic       pc,
   output logic       busy,
   output logic       no_move
);

   state_t          r_state;
   logic [3:0]      r_idx;
   logic [8:0][1:0] r_board;
   logic [3:0]      r_pos;
   logic            r_pc;
   logic            r_busy;
   logic            r_no_move;

   state_t          w_next_state;
   logic [3:0]      w_next_idx;
   logic [3:0]      w_next_pos;
   logic            w_next_no_move;
   logic            w_capture;
   logic [2:0]      w_line;
   logic [1:0]      w_owner;
   logic            w_line_hit;
   logic [1:0]      w_line_slot;
   logic [3:0]      w_hit_cell;
   logic [3:0]      w_pref_cell;
   logic            w_pref_hit;

   assign w_line = r_idx[2:0];
`ifdef TTT_MOVEGEN_BLOCK_EN
   assign w_owner = (r_state == ST_SCAN_BLOCK) ? CELL_PLAYER : CELL_COMPUTER;
`else
   assign w_owner = CELL_COMPUTER;
`endif

   ttt_line_eval u_line_eval (
      .i_cell_a (r_board[line_cell(w_line, 2'd0)]),
      .i_cell_b (r_board[line_cell(w_line, 2'd1)]),
      .i_cell_c (r_board[line_cell(w_line, 2'd2)]),
      .i_owner  (w_owner),
      .o_hit    (w_line_hit),
      .o_slot   (w_line_slot)
   );

   assign w_hit_cell  = line_cell(w_line, w_line_slot);
   assign w_pref_cell = pref_cell(r_idx);
   assign w_pref_hit  = (r_board[w_pref_cell] == CELL_EMPTY);

   // Next-state logic; aborts are tested before any hit so they win a same-cycle tie.
   always_comb begin
      w_next_state   = r_state;
      w_next_idx     = r_idx;
      w_next_pos     = r_pos;
      w_next_no_move = 1'b0;
      w_capture      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req && !game_over) begin
               w_capture    = 1'b1;
               w_next_idx   = 4'd0;
               w_next_state = ST_SCAN_WIN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
`ifdef TTT_MOVEGEN_BLOCK_EN
         ST_SCAN_WIN, ST_SCAN_BLOCK: begin
`else
         ST_SCAN_WIN: begin
`endif
            if (!req) begin
               w_next_state = ST_IDLE;
            end else if (game_over) begin
               w_next_state = ST_WAIT_DROP;
            end else if (w_line_hit) begin
               w_next_pos   = w_hit_cell;
               w_next_state = ST_ISSUE;
            end else if (r_idx == LAST_LINE) begin
               w_next_idx = 4'd0;
`ifdef TTT_MOVEGEN_BLOCK_EN
               w_next_state = (r_state == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_SCAN_PREF;
`else
               w_next_state = ST_SCAN_PREF;
`endif
            end else begin
               w_next_idx = r_idx + 4'd1;
            end
         end
         ST_SCAN_PREF: begin
            if (!req) begin
               w_next_state = ST_IDLE;
            end else if (game_over) begin
               w_next_state = ST_WAIT_DROP;
            end else if (w_pref_hit) begin
               w_next_pos   = w_pref_cell;
               w_next_state = ST_ISSUE;
            end else if (r_idx == LAST_PREF) begin
               w_next_no_move = 1'b1;
               w_next_idx     = 4'd0;
               w_next_state   = ST_WAIT_DROP;
            end else begin
               w_next_idx = r_idx + 4'd1;
            end
         end
         ST_ISSUE: begin
            w_next_state = ST_WAIT_DROP;
         end
         ST_WAIT_DROP: begin
            if (!req) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_WAIT_DROP;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State, snapshot and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_idx     <= 4'd0;
         r_board   <= '0;
         r_pos     <= 4'd0;
         r_pc      <= 1'b0;
         r_busy    <= 1'b0;
         r_no_move <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_idx     <= w_next_idx;
         r_pos     <= w_next_pos;
         r_pc      <= (w_next_state == ST_ISSUE);
         r_busy    <= (w_next_state != ST_IDLE) && (w_next_state != ST_WAIT_DROP);
         r_no_move <= w_next_no_move;
         if (w_capture) begin
            r_board <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
         end else begin
            r_board <= r_board;
         end
      end
   end

   assign computer_position = r_pos;
   assign pc                = r_pc;
   assign busy              = r_busy;
   assign no_move           = r_no_move;

endmodule

// File: tb/tb_ttt_move_generator.sv
// Directed bench for ttt_move_generator: table of boards with hand-computed move/latency,
// plus abort, snapshot and reset sequences.
module tb_ttt_move_generator;

   localparam int WIN_BASE = 2;
`ifdef TTT_MOVEGEN_BLOCK_EN
   localparam int BLOCK_BASE = 10;
   localparam int PREF_BASE  = 18;
`else
   localparam int PREF_BASE  = 10;
`endif
   localparam int NVEC = 9;

   typedef struct {
      string           name;
      logic [0:8][1:0] cells;
      int              exp_cyc;
      int              exp_pos;
      bit              exp_nomove;
   } vec_t;

   logic       clock;
   logic       reset;
   logic [1:0] board [9];
   logic       req;
   logic       game_over;
   logic [3:0] computer_position;
   logic       pc;
   logic       busy;
   logic       no_move;

   int n_cmp;
   int n_fail;
   vec_t vecs [NVEC];

   ttt_move_generator dut (
      .clock             (clock),
      .reset             (reset),
      .pos1              (board[0]),
      .pos2              (board[1]),
      .pos3              (board[2]),
      .pos4              (board[3]),
      .pos5              (board[4]),
      .pos6              (board[5]),
      .pos7              (board[6]),
      .pos8              (board[7]),
      .pos9              (board[8]),
      .req               (req),
      .game_over         (game_over),
      .computer_position (computer_position),
      .pc                (pc),
      .busy              (busy),
      .no_move           (no_move)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_board(input logic [0:8][1:0] cells);
      for (int i = 0; i < 9; i++) board[i] = cells[i];
   endtask

   task automatic next_cycle();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Raise req at a negedge, watch 40 cycles (cycle 1 = period after the capture edge).
   task automatic run_vec(input vec_t v);
      int pc_cnt, pc_cyc, pc_pos, nm_cnt, nm_cyc, busy1, busy_after, strobe_cyc;
      pc_cnt = 0; pc_cyc = -1; pc_pos = -1; nm_cnt = 0; nm_cyc = -1;
      busy1 = -1; busy_after = -1; strobe_cyc = -1;
      set_board(v.cells);
      req = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         next_cycle();
         if (cyc == 1) busy1 = int'(busy);
         if (strobe_cyc > 0 && cyc == strobe_cyc + 1) busy_after = int'(busy);
         if (pc === 1'b1) begin
            pc_cnt++;
            if (pc_cyc < 0) begin
               pc_cyc = cyc; pc_pos = int'(computer_position); strobe_cyc = cyc;
            end
         end
         if (no_move === 1'b1) begin
            nm_cnt++;
            if (nm_cyc < 0) begin
               nm_cyc = cyc; strobe_cyc = cyc;
            end
         end
      end
      check({v.name, " busy_cycle1"}, busy1, 1);
      check({v.name, " busy_after_strobe"}, busy_after, 0);
      if (v.exp_nomove) begin
         check({v.name, " no_move_count"}, nm_cnt, 1);
         check({v.name, " no_move_cycle"}, nm_cyc, v.exp_cyc);
         check({v.name, " pc_count"}, pc_cnt, 0);
      end else begin
         check({v.name, " pc_count"}, pc_cnt, 1);
         check({v.name, " pc_cycle"}, pc_cyc, v.exp_cyc);
         check({v.name, " position"}, pc_pos, v.exp_pos);
         check({v.name, " no_move_count"}, nm_cnt, 0);
      end
      req = 1'b0;
      next_cycle();
   endtask

   // Count strobes over a quiet window that must produce none.
   task automatic expect_quiet(input string name, input int cycles);
      int strobes;
      strobes = 0;
      for (int c = 0; c < cycles; c++) begin
         next_cycle();
         if (pc === 1'b1 || no_move === 1'b1) strobes++;
      end
      check({name, " strobes"}, strobes, 0);
   endtask

   initial begin
      vec_t v;
      int pc_cyc, pc_pos;
      n_cmp = 0; n_fail = 0;
      clock = 1'b0; reset = 1'b0; req = 1'b0; game_over = 1'b0;
      set_board('0);

      vecs[0] = '{"empty", {2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00}, PREF_BASE, 4, 1'b0};
      vecs[1] = '{"win_line0", {2'b10,2'b10,2'b00, 2'b00,2'b01,2'b00, 2'b00,2'b00,2'b01}, WIN_BASE, 2, 1'b0};
`ifdef TTT_MOVEGEN_BLOCK_EN
      vecs[2] = '{"block_line1", {2'b10,2'b00,2'b00, 2'b01,2'b01,2'b00, 2'b00,2'b00,2'b00}, BLOCK_BASE + 1, 5, 1'b0};
      vecs[8] = '{"block_line6", {2'b01,2'b00,2'b00, 2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01}, BLOCK_BASE + 6, 4, 1'b0};
`else
      vecs[2] = '{"no_block_pref2", {2'b10,2'b00,2'b00, 2'b01,2'b01,2'b00, 2'b00,2'b00,2'b00}, PREF_BASE + 2, 2, 1'b0};
      vecs[8] = '{"no_block_pref0", {2'b01,2'b00,2'b00, 2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01}, PREF_BASE, 4, 1'b0};
`endif
      vecs[3] = '{"full_board", {2'b01,2'b10,2'b01, 2'b01,2'b10,2'b10, 2'b10,2'b01,2'b11}, PREF_BASE + 8, 0, 1'b1};
      vecs[4] = '{"win_line7", {2'b01,2'b00,2'b10, 2'b00,2'b10,2'b00, 2'b00,2'b00,2'b00}, WIN_BASE + 7, 6, 1'b0};
      vecs[5] = '{"pref_last", {2'b11,2'b01,2'b11, 2'b11,2'b10,2'b11, 2'b01,2'b00,2'b10}, PREF_BASE + 8, 7, 1'b0};
      vecs[6] = '{"win_over_block", {2'b10,2'b10,2'b00, 2'b01,2'b01,2'b00, 2'b00,2'b00,2'b00}, WIN_BASE, 2, 1'b0};
      vecs[7] = '{"code11_neither", {2'b11,2'b11,2'b00, 2'b00,2'b11,2'b00, 2'b00,2'b00,2'b00}, PREF_BASE + 2, 2, 1'b0};

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset pc", int'(pc), 0);
      check("reset busy", int'(busy), 0);
      check("reset no_move", int'(no_move), 0);
      check("reset position", int'(computer_position), 0);
      reset = 1'b1;
      next_cycle();

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

      // req dropped during cycle 5: back to IDLE, busy low in cycle 6, no strobe.
      set_board('0);
      req = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) next_cycle();
      check("req_drop busy_cycle5", int'(busy), 1);
      req = 1'b0;
      next_cycle();
      check("req_drop busy_cycle6", int'(busy), 0);
      expect_quiet("req_drop", 30);

      // game_over mid-scan: WAIT_DROP with no strobes even after game_over clears.
      req = 1'b1;
      for (int cyc = 1; cyc <= 3; cyc++) next_cycle();
      game_over = 1'b1;
      next_cycle();
      check("game_over busy", int'(busy), 0);
      game_over = 1'b0;
      expect_quiet("game_over", 30);
      req = 1'b0;
      next_cycle();

      // Board changes after capture must not affect the move.
      set_board('0);
      req = 1'b1;
      pc_cyc = -1; pc_pos = -1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         next_cycle();
         if (cyc == 1) begin
            v.cells = {2'b10,2'b10,2'b00, 2'b01,2'b01,2'b00, 2'b00,2'b00,2'b00};
            set_board(v.cells);
         end
         if (pc === 1'b1 && pc_cyc < 0) begin
            pc_cyc = cyc; pc_pos = int'(computer_position);
         end
      end
      check("snapshot pc_cycle", pc_cyc, PREF_BASE);
      check("snapshot position", pc_pos, 4);
      req = 1'b0;
      set_board('0);
      next_cycle();

      // Reset during cycle 5 of a scan clears every output.
      req = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) next_cycle();
      reset = 1'b0;
      req = 1'b0;
      next_cycle();
      check("midreset pc", int'(pc), 0);
      check("midreset busy", int'(busy), 0);
      check("midreset no_move", int'(no_move), 0);
      check("midreset position", int'(computer_position), 0);
      reset = 1'b1;
      expect_quiet("midreset", 20);

      // A fresh request after reset still lands at the preference latency.
      run_vec(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
